booth_pp_stream: RTL and testbench



---
 rtl/booth_pp_stream_pkg.sv | 31 +++
 rtl/booth_pp_stream_if.sv | 33 +++
 rtl/booth_pp_stream_row.sv | 35 +++
 rtl/booth_pp_stream.sv | 109 ++++++++++
 tb/tb_booth_pp_stream.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pp_stream_pkg.sv
// booth_pkg: Booth digit type, radix-4 encoder and width helpers
// shared by the partial-product generator and its row slices.
package booth_pkg;

  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } booth_digit_t;

  function automatic int npp_of(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int pw_of(input int w);
    return 2 * w;
  endfunction

  function automatic booth_digit_t booth_encode(input logic [2:0] b);
    booth_digit_t d;
    d = '0;
    unique case (b)
      3'b001, 3'b010: begin d.neg = 1'b0; d.mag = 2'd1; end
      3'b011:         begin d.neg = 1'b0; d.mag = 2'd2; end
      3'b100:         begin d.neg = 1'b1; d.mag = 2'd2; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.mag = 2'd1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_stream_if.sv
// booth_pp_stream_if: operand-in / rows-out valid-ready bundle.
// master drives operands and out_ready; slave is the generator.
interface booth_pp_stream_if
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int NPP = npp_of(WIDTH);
  localparam int PW  = pw_of(WIDTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        x;
  logic [WIDTH-1:0]        y;
  logic                    is_signed;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [(NPP+1)*PW-1:0]   pp;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, x, y, is_signed, in_tag, out_ready,
    input  in_ready, out_valid, pp, out_tag
  );

  modport slave (
    input  in_valid, x, y, is_signed, in_tag, out_ready,
    output in_ready, out_valid, pp, out_tag
  );

endinterface

// File: rtl/booth_pp_stream_row.sv
// booth_row: one radix-4 Booth partial-product row, already shifted
// into place; negative digits emit ~M and flag neg for the +1 row.
module booth_row
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX   = 0
) (
  input  logic [WIDTH:0]     ye,
  input  booth_digit_t       dig,
  output logic [2*WIDTH-1:0] row,
  output logic               neg
);
  localparam int MW = WIDTH + 2;
  localparam int PW = pw_of(WIDTH);

  logic [MW-1:0] m;
  logic [MW-1:0] v;
  logic [PW-1:0] ext;

  // magnitude select, conditional invert, sign-extend and place
  always_comb begin
    unique case (dig.mag)
      2'd1:    m = {ye[WIDTH], ye};
      2'd2:    m = {ye, 1'b0};
      default: m = '0;
    endcase
    v   = dig.neg ? ~m : m;
    ext = {{(PW-MW){v[MW-1]}}, v};
    row = ext << (2 * IDX);
  end

  assign neg = dig.neg;

endmodule

// File: rtl/booth_pp_stream.sv
// booth_pp_stream: two-stage radix-4 Booth partial-product generator
// with bubble-free valid/ready flow control on both sides.
import booth_pkg::*;

module booth_pp_stream #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  booth_pp_stream_if.slave   bus
);
  localparam int NPP = npp_of(WIDTH);
  localparam int PW  = pw_of(WIDTH);
  localparam int XW  = WIDTH + 2;
  localparam int YW  = WIDTH + 1;
  localparam int OW  = (NPP + 1) * PW;

  logic             v1;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             s1;
  logic [TAG_W-1:0] t1;

  logic             v2;
  logic [OW-1:0]    pp2;
  logic [TAG_W-1:0] t2;

  logic             adv1;
  logic             adv2;

  logic [XW-1:0]    xe;
  logic [XW:0]      xp;
  logic [YW-1:0]    ye;
  booth_digit_t     dig [NPP];
  logic [NPP-1:0]   neg;
  logic [PW-1:0]    corr;
  logic [OW-1:0]    pp_d;

  assign adv2 = !v2 || bus.out_ready;
  assign adv1 = !v1 || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v2;
  assign bus.pp        = pp2;
  assign bus.out_tag   = t2;

  assign xe = s1 ? {{2{x1[WIDTH-1]}}, x1} : {2'b00, x1};
  assign ye = s1 ? {y1[WIDTH-1], y1} : {1'b0, y1};
  assign xp = {xe, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_row
    assign dig[i] = booth_encode(xp[2*i+2 -: 3]);
    booth_row #(
      .WIDTH (WIDTH),
      .IDX   (i)
    ) u_row (
      .ye  (ye),
      .dig (dig[i]),
      .row (pp_d[i*PW +: PW]),
      .neg (neg[i])
    );
  end

  // +1 for every inverted row; positions 2i never overlap
  always_comb begin
    corr = '0;
    for (int i = 0; i < NPP; i++) begin
      corr[2*i] = neg[i];
    end
  end

  assign pp_d[NPP*PW +: PW] = corr;

  // stage 1: operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      s1 <= 1'b0;
      t1 <= '0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        x1 <= bus.x;
        y1 <= bus.y;
        s1 <= bus.is_signed;
        t1 <= bus.in_tag;
      end
    end
  end

  // stage 2: encoded rows and tag, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      pp2 <= '0;
      t2  <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        pp2 <= pp_d;
        t2  <= t1;
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_stream.sv
// tb_booth_pp_stream: scoreboard bench over WIDTH 8/16/32 instances;
// row sums are compared with a plain 64-bit multiply.
module tb_booth_pp_stream;
  import booth_pkg::*;

  localparam int NW    = 3;
  localparam int TAG_W = 4;
  localparam int PPMAX = 1152;

  typedef struct packed {
    logic [63:0] prod;
    logic [3:0]  tag;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic             in_valid_a  [NW];
  logic             in_ready_a  [NW];
  logic [31:0]      x_a         [NW];
  logic [31:0]      y_a         [NW];
  logic             is_signed_a [NW];
  logic [3:0]       in_tag_a    [NW];
  logic             out_valid_a [NW];
  logic             out_ready_a [NW];
  logic [3:0]       out_tag_a   [NW];
  logic [63:0]      sum_a       [NW];
  logic [PPMAX-1:0] pp_a        [NW];

  int checks   = 0;
  int failures = 0;
  sb_t sb[$];

  for (genvar g = 0; g < NW; g++) begin : gw
    localparam int W = 8 << g;
    localparam int P = 2 * W;
    localparam int R = W / 2 + 2;
    logic [P-1:0] s;

    booth_pp_stream_if #(.WIDTH(W), .TAG_W(TAG_W)) ifc ();

    assign ifc.in_valid  = in_valid_a[g];
    assign ifc.x         = x_a[g][W-1:0];
    assign ifc.y         = y_a[g][W-1:0];
    assign ifc.is_signed = is_signed_a[g];
    assign ifc.in_tag    = in_tag_a[g];
    assign ifc.out_ready = out_ready_a[g];
    assign in_ready_a[g]  = ifc.in_ready;
    assign out_valid_a[g] = ifc.out_valid;
    assign out_tag_a[g]   = ifc.out_tag;
    assign pp_a[g]        = PPMAX'(ifc.pp);

    always_comb begin
      s = '0;
      for (int k = 0; k < R; k++) s = s + ifc.pp[k*P +: P];
    end
    assign sum_a[g] = 64'(s);

    booth_pp_stream #(.WIDTH(W), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask_w(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic sg);
    logic [63:0] ae, be, pm;
    logic [31:0] m;
    m  = mask_w(w);
    ae = {32'b0, a & m};
    be = {32'b0, b & m};
    if (sg && a[w-1]) ae = ae | (~64'b0 << w);
    if (sg && b[w-1]) be = be | (~64'b0 << w);
    pm = (w == 32) ? ~64'b0 : ((64'd1 << (2 * w)) - 64'd1);
    return (ae * be) & pm;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] m);
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0:       r = m;
      1:       r = (m >> 1) + 32'd1;
      2:       r = 32'd0;
      default: r = $urandom & m;
    endcase
    return r;
  endfunction

  task automatic run_one(input int g, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [3:0] tag,
                         output logic ok, output int lat);
    in_valid_a[g]  = 1'b1;
    x_a[g]         = a;
    y_a[g]         = b;
    is_signed_a[g] = sg;
    in_tag_a[g]    = tag;
    out_ready_a[g] = 1'b1;
    ok  = 1'b0;
    lat = 0;
    #1;
    for (int c = 0; c < 8 && !in_ready_a[g]; c++) begin
      step();
      #1;
    end
    step();
    lat = 1;
    in_valid_a[g] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid_a[g]) begin
        ok = 1'b1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < NW; g++) begin
      in_valid_a[g] = 1'b0; x_a[g] = '0; y_a[g] = '0;
      is_signed_a[g] = 1'b0; in_tag_a[g] = '0; out_ready_a[g] = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < NW; g++) begin
      checks++;
      if (out_valid_a[g] !== 1'b0) begin
        failures++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", g, out_valid_a[g]);
      end
      checks++;
      if (pp_a[g] !== '0) begin
        failures++; $display("FAIL reset_pp[%0d] got nonzero exp=0", g);
      end
      checks++;
      if (out_tag_a[g] !== 4'h0) begin
        failures++; $display("FAIL reset_out_tag[%0d] got=%h exp=0", g, out_tag_a[g]);
      end
      checks++;
      if (in_ready_a[g] !== 1'b1) begin
        failures++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", g, in_ready_a[g]);
      end
    end
    step();
    rst = 1'b0;
    #1;
    for (int g = 0; g < NW; g++) begin
      checks++;
      if (in_ready_a[g] !== 1'b1) begin
        failures++; $display("FAIL post_reset_in_ready[%0d] got=%b exp=1", g, in_ready_a[g]);
      end
      out_ready_a[g] = 1'b1;
    end
  endtask

  task automatic test_rows_w8();
    logic [15:0] exp_rows [6];
    logic ok;
    int lat;
    exp_rows[0] = 16'hFFFA; exp_rows[1] = 16'h0014; exp_rows[2] = 16'h0000;
    exp_rows[3] = 16'h0000; exp_rows[4] = 16'h0000; exp_rows[5] = 16'h0001;
    step();
    run_one(0, 32'h03, 32'h05, 1'b1, 4'hA, ok, lat);
    checks++;
    if (ok !== 1'b1) begin
      failures++; $display("FAIL w8_timeout got=%b exp=1", ok);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pp_a[0][k*16 +: 16] !== exp_rows[k]) begin
        failures++;
        $display("FAIL w8_row%0d got=%h exp=%h", k, pp_a[0][k*16 +: 16], exp_rows[k]);
      end
    end
    checks++;
    if (sum_a[0] !== 64'h000F) begin
      failures++; $display("FAIL w8_sum got=%h exp=000f", sum_a[0]);
    end
    checks++;
    if (out_tag_a[0] !== 4'hA) begin
      failures++; $display("FAIL w8_tag got=%h exp=a", out_tag_a[0]);
    end
  endtask

  task automatic test_wide();
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic        ss [3];
    logic [63:0] es [3];
    logic ok;
    int lat;
    xs[0] = 32'hFFFF_FFFF; ys[0] = 32'h8000_0000; ss[0] = 1'b1; es[0] = 64'h0000_0000_8000_0000;
    xs[1] = 32'hFFFF_FFFF; ys[1] = 32'h8000_0000; ss[1] = 1'b0; es[1] = 64'h7FFF_FFFF_8000_0000;
    xs[2] = 32'hFFFF_FFFF; ys[2] = 32'hFFFF_FFFF; ss[2] = 1'b0; es[2] = 64'hFFFF_FFFE_0000_0001;
    step();
    for (int i = 0; i < 3; i++) begin
      run_one(2, xs[i], ys[i], ss[i], 4'(i + 5), ok, lat);
      checks++;
      if (ok !== 1'b1) begin
        failures++; $display("FAIL w32_case%0d_timeout got=%b exp=1", i, ok);
      end
      checks++;
      if (sum_a[2] !== es[i]) begin
        failures++; $display("FAIL w32_case%0d_sum got=%h exp=%h", i, sum_a[2], es[i]);
      end
      checks++;
      if (out_tag_a[2] !== 4'(i + 5)) begin
        failures++; $display("FAIL w32_case%0d_tag got=%h exp=%h", i, out_tag_a[2], 4'(i + 5));
      end
      if (i == 0) begin
        checks++;
        if (lat != 2) begin
          failures++; $display("FAIL w32_latency got=%0d exp=2", lat);
        end
      end
      if (i == 2) begin
        checks++;
        if (pp_a[2][16*64 +: 64] !== 64'hFFFF_FFFF_0000_0000) begin
          failures++;
          $display("FAIL w32_top_row got=%h exp=ffffffff00000000", pp_a[2][16*64 +: 64]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic [PPMAX-1:0] snap_pp;
    logic [3:0] snap_tag;
    logic held;
    int sent, got, g;
    sb_t e;
    g = 2;
    xs[0] = 32'h1234_5678; ys[0] = 32'hDEAD_BEEF;
    xs[1] = 32'h8000_0001; ys[1] = 32'h7FFF_FFFF;
    xs[2] = 32'hCAFE_F00D; ys[2] = 32'h0000_0003;
    step();
    sb.delete();
    sent = 0; got = 0; held = 1'b0;
    snap_pp = '0; snap_tag = '0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      out_ready_a[g] = (cyc >= 5);
      in_valid_a[g]  = (sent < 3);
      if (sent < 3) begin
        x_a[g] = xs[sent]; y_a[g] = ys[sent];
        is_signed_a[g] = sent[0]; in_tag_a[g] = 4'(sent + 1);
      end
      #1;
      if (cyc == 4) begin
        checks++;
        if (in_ready_a[g] !== 1'b0) begin
          failures++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready_a[g]);
        end
        checks++;
        if (sent != 2) begin
          failures++; $display("FAIL bp_accept_count got=%0d exp=2", sent);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (in_ready_a[g] !== 1'b1) begin
          failures++; $display("FAIL bp_in_ready_release got=%b exp=1", in_ready_a[g]);
        end
      end
      if (out_valid_a[g] && !out_ready_a[g]) begin
        if (!held) begin
          held = 1'b1; snap_pp = pp_a[g]; snap_tag = out_tag_a[g];
        end else begin
          checks++;
          if (pp_a[g] !== snap_pp) begin
            failures++; $display("FAIL bp_pp_stable got_sum=%h cyc=%0d", sum_a[g], cyc);
          end
          checks++;
          if (out_tag_a[g] !== snap_tag) begin
            failures++; $display("FAIL bp_tag_stable got=%h exp=%h", out_tag_a[g], snap_tag);
          end
        end
      end else begin
        held = 1'b0;
      end
      if (out_valid_a[g] && out_ready_a[g]) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL bp_spurious got tag=%h exp none", out_tag_a[g]);
        end else begin
          e = sb.pop_front();
          checks++;
          if (out_tag_a[g] !== e.tag) begin
            failures++; $display("FAIL bp_tag_order got=%h exp=%h", out_tag_a[g], e.tag);
          end
          if (sum_a[g] !== e.prod) begin
            failures++; $display("FAIL bp_sum got=%h exp=%h", sum_a[g], e.prod);
          end
        end
        got++;
      end
      if (in_valid_a[g] && in_ready_a[g]) begin
        e.prod = ref_prod(32, x_a[g], y_a[g], is_signed_a[g]);
        e.tag  = in_tag_a[g];
        sb.push_back(e);
        sent++;
      end
      step();
    end
    in_valid_a[g]  = 1'b0;
    out_ready_a[g] = 1'b1;
    checks++;
    if (got != 3) begin
      failures++; $display("FAIL bp_count got=%0d exp=3", got);
    end
  endtask

  task automatic test_reset_midflight();
    int g, stale;
    g = 2;
    step();
    out_ready_a[g] = 1'b0;
    in_valid_a[g]  = 1'b1;
    x_a[g] = 32'h0000_0007; y_a[g] = 32'h0000_0009;
    is_signed_a[g] = 1'b0; in_tag_a[g] = 4'hC;
    step();
    step();
    in_valid_a[g] = 1'b0;
    #1;
    checks++;
    if (out_valid_a[g] !== 1'b1 || in_ready_a[g] !== 1'b0) begin
      failures++;
      $display("FAIL mid_fill got valid=%b ready=%b exp valid=1 ready=0",
               out_valid_a[g], in_ready_a[g]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid_a[g] !== 1'b0) begin
      failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid_a[g]);
    end
    checks++;
    if (pp_a[g] !== '0) begin
      failures++; $display("FAIL mid_rst_pp got_sum=%h exp=0", sum_a[g]);
    end
    checks++;
    if (out_tag_a[g] !== 4'h0) begin
      failures++; $display("FAIL mid_rst_tag got=%h exp=0", out_tag_a[g]);
    end
    checks++;
    if (in_ready_a[g] !== 1'b1) begin
      failures++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready_a[g]);
    end
    step();
    rst = 1'b0;
    out_ready_a[g] = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid_a[g]) stale++;
      step();
    end
    checks++;
    if (stale != 0) begin
      failures++; $display("FAIL mid_stale got=%0d exp=0", stale);
    end
    checks++;
    if (in_ready_a[g] !== 1'b1) begin
      failures++; $display("FAIL mid_after_ready got=%b exp=1", in_ready_a[g]);
    end
  endtask

  task automatic test_random(input int g, input int n);
    int w, sent, got, cyc;
    logic [31:0] m;
    logic acc;
    sb_t e;
    w = 8 << g;
    m = mask_w(w);
    step();
    sb.delete();
    sent = 0; got = 0; cyc = 0; acc = 1'b1;
    in_valid_a[g] = 1'b0;
    while (got < n && cyc < 8 * n) begin
      if (acc || !in_valid_a[g]) begin
        acc = 1'b0;
        in_valid_a[g]  = (sent < n) && ($urandom_range(0, 3) != 0);
        x_a[g]         = pick(m);
        y_a[g]         = pick(m);
        is_signed_a[g] = 1'($urandom_range(0, 1));
        in_tag_a[g]    = 4'($urandom);
      end
      out_ready_a[g] = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid_a[g] && out_ready_a[g]) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rnd_w%0d_spurious got tag=%h exp none", w, out_tag_a[g]);
        end else begin
          e = sb.pop_front();
          checks++;
          if (sum_a[g] !== e.prod || out_tag_a[g] !== e.tag) begin
            failures++;
            $display("FAIL rnd_w%0d got sum=%h tag=%h exp sum=%h tag=%h",
                     w, sum_a[g], out_tag_a[g], e.prod, e.tag);
          end
        end
        got++;
      end
      if (in_valid_a[g] && in_ready_a[g]) begin
        e.prod = ref_prod(w, x_a[g], y_a[g], is_signed_a[g]);
        e.tag  = in_tag_a[g];
        sb.push_back(e);
        sent++;
        acc = 1'b1;
      end
      step();
      cyc++;
    end
    in_valid_a[g]  = 1'b0;
    out_ready_a[g] = 1'b1;
    checks++;
    if (got != n || sent != got || sb.size() != 0) begin
      failures++;
      $display("FAIL rnd_w%0d_count got in=%0d out=%0d left=%0d exp %0d", w, sent, got,
               sb.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_rows_w8();
    test_wide();
    test_backpressure();
    test_reset_midflight();
    test_random(0, 3400);
    test_random(1, 3300);
    test_random(2, 3300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
